retire_monitor: RTL and testbench

- Synthesizable retire/commit monitor downstream of the pipelined cpu core.
- Consumes the writeback and memory-stage commit signals (register write, load, store, halt) and converts them into an ordered event stream behind a valid/ready handshake.
- Maintains cycle and instruction performance counters and a halt/timeout drain FSM.
- Gives on-chip and bench-level trace capture a single clean consumer interface.

---
 rtl/retire_monitor.sv | 190 +++++++++++++++++++
 tb/tb_retire_monitor.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_monitor.sv
// Retire/commit monitor: turns writeback and memory-stage commits into an
// ordered valid/ready event stream, keeps run-time performance counters and
// drains the event queue after a halt or a cycle-limit timeout.
module retire_monitor #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned MAX_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_regwrite,
  input  logic [3:0]  w_dest,
  input  logic [15:0] w_data,
  input  logic        m_memread,
  input  logic        m_memwrite,
  input  logic [15:0] m_addr,
  input  logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  input  logic        hlt,
  input  logic        ev_ready,
  output logic        ev_valid,
  output logic [1:0]  ev_type,
  output logic [15:0] ev_tag,
  output logic [15:0] ev_value,
  output logic [31:0] cycle_cnt,
  output logic [31:0] inst_cnt,
  output logic [15:0] drop_cnt,
  output logic        overflow,
  output logic        timeout,
  output logic        done
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned FREE_W = CNT_W + 1;
  localparam logic [31:0] CYCLE_LIMIT = 32'(MAX_CYCLES - 1);

  localparam logic [1:0] EV_REG   = 2'b00;
  localparam logic [1:0] EV_LOAD  = 2'b01;
  localparam logic [1:0] EV_STORE = 2'b10;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]  evType;
    logic [15:0] tag;
    logic [15:0] value;
  } event_t;

  state_t           state;
  state_t           nextState;
  event_t           mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] nextCount;

  logic              inRun;
  logic              regEv;
  logic              memEv;
  logic              pop;
  logic              limitHit;
  logic [1:0]        numReq;
  logic [1:0]        numPush;
  logic [1:0]        numDrop;
  logic [FREE_W-1:0] freeSlots;
  logic [16:0]       dropSum;
  event_t            regEntry;
  event_t            memEntry;
  event_t            firstEntry;
  event_t            head;

  // Event qualification, slot accounting and the timeout condition
  always_comb begin
    inRun = (state == RUN);
    regEv = inRun && w_regwrite;
    memEv = inRun && (m_memwrite || m_memread);

    regEntry.evType = EV_REG;
    regEntry.tag    = 16'(w_dest);
    regEntry.value  = w_data;

    memEntry.evType = m_memwrite ? EV_STORE : EV_LOAD;
    memEntry.tag    = m_addr;
    memEntry.value  = m_memwrite ? m_wdata : m_rdata;

    // REG always goes first when both are present
    firstEntry = regEv ? regEntry : memEntry;

    pop       = ev_valid && ev_ready;
    numReq    = 2'(regEv) + 2'(memEv);
    freeSlots = FREE_W'(DEPTH) - FREE_W'(count) + FREE_W'(pop);
    if (freeSlots >= FREE_W'(numReq)) begin
      numPush = numReq;
    end else begin
      numPush = freeSlots[1:0];
    end
    numDrop   = numReq - numPush;
    nextCount = count + CNT_W'(numPush) - CNT_W'(pop);
    dropSum   = 17'(drop_cnt) + 17'(numDrop);
    limitHit  = inRun && !hlt && (cycle_cnt == CYCLE_LIMIT);
  end

  // Event storage; up to two writes per cycle at consecutive slots
  always_ff @(posedge clk) begin
    if (numPush != 2'd0) begin
      mem[wrPtr] <= firstEntry;
    end
    if (numPush == 2'd2) begin
      mem[wrPtr + PTR_W'(1)] <= memEntry;
    end
  end

  // Queue pointers, occupancy and registered valid flag
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      ev_valid <= 1'b0;
    end else begin
      wrPtr    <= wrPtr + PTR_W'(numPush);
      rdPtr    <= rdPtr + PTR_W'(pop);
      count    <= nextCount;
      ev_valid <= (nextCount != '0);
    end
  end

  // First-word-fall-through head; zeroed while nothing is valid
  always_comb begin
    head = mem[rdPtr];
    if (!ev_valid) begin
      head = '0;
    end
    ev_type  = head.evType;
    ev_tag   = head.tag;
    ev_value = head.value;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  // FSM next state: halt or limit ends RUN, an empty queue ends DRAIN
  always_comb begin
    nextState = state;
    case (state)
      RUN:     if (hlt || limitHit) nextState = DRAIN;
      DRAIN:   if (count == '0) nextState = DONE;
      DONE:    nextState = DONE;
      default: nextState = RUN;
    endcase
  end

  // Performance counters and sticky status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
      timeout   <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (inRun) begin
        cycle_cnt <= cycle_cnt + 32'd1;
        if (hlt || w_regwrite || m_memwrite) begin
          inst_cnt <= inst_cnt + 32'd1;
        end
      end
      if (numDrop != 2'd0) begin
        overflow <= 1'b1;
        drop_cnt <= dropSum[16] ? 16'hFFFF : dropSum[15:0];
      end
      if (limitHit) begin
        timeout <= 1'b1;
      end
      done <= (nextState == DONE);
    end
  end

endmodule

// File: tb/tb_retire_monitor.sv
// Self-checking bench for retire_monitor with a queue-based reference model.
module tb_retire_monitor;

  localparam int DEPTH = 8;
  localparam int MAXC  = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        w_regwrite = 1'b0;
  logic [3:0]  w_dest = '0;
  logic [15:0] w_data = '0;
  logic        m_memread = 1'b0;
  logic        m_memwrite = 1'b0;
  logic [15:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_rdata = '0;
  logic        hlt = 1'b0;
  logic        ev_ready = 1'b0;
  logic        ev_valid;
  logic [1:0]  ev_type;
  logic [15:0] ev_tag;
  logic [15:0] ev_value;
  logic [31:0] cycle_cnt;
  logic [31:0] inst_cnt;
  logic [15:0] drop_cnt;
  logic        overflow;
  logic        timeout;
  logic        done;

  retire_monitor #(.DEPTH(DEPTH), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst),
    .w_regwrite(w_regwrite), .w_dest(w_dest), .w_data(w_data),
    .m_memread(m_memread), .m_memwrite(m_memwrite), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .hlt(hlt), .ev_ready(ev_ready),
    .ev_valid(ev_valid), .ev_type(ev_type), .ev_tag(ev_tag), .ev_value(ev_value),
    .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt), .drop_cnt(drop_cnt),
    .overflow(overflow), .timeout(timeout), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  t;
    logic [15:0] tag;
    logic [15:0] val;
  } ev_t;

  // Reference model state: 0 = running, 1 = draining, 2 = finished
  ev_t mq[$];
  int  mCycle = 0;
  int  mInst  = 0;
  int  mDrop  = 0;
  bit  mOvf   = 1'b0;
  bit  mTmo   = 1'b0;
  int  mPhase = 0;

  int nChecks = 0;
  int nPass   = 0;

  // One clock of the model, using the inputs present at the edge
  task automatic modelStep();
    ev_t cand[$];
    int  startSize;
    bit  doPop;
    if (rst) begin
      mq.delete();
      mCycle = 0; mInst = 0; mDrop = 0; mOvf = 1'b0; mTmo = 1'b0; mPhase = 0;
      return;
    end
    startSize = mq.size();
    doPop = (startSize > 0) && ev_ready;
    if (mPhase == 0) begin
      if (w_regwrite) cand.push_back({2'b00, {12'h000, w_dest}, w_data});
      if (m_memwrite) cand.push_back({2'b10, m_addr, m_wdata});
      else if (m_memread) cand.push_back({2'b01, m_addr, m_rdata});
    end
    if (doPop) void'(mq.pop_front());
    foreach (cand[i]) begin
      if (mq.size() < DEPTH) mq.push_back(cand[i]);
      else begin
        if (mDrop < 65535) mDrop++;
        mOvf = 1'b1;
      end
    end
    if (mPhase == 0) begin
      mCycle++;
      if (hlt || w_regwrite || m_memwrite) mInst++;
      if (hlt) mPhase = 1;
      else if (mCycle == MAXC) begin
        mTmo = 1'b1;
        mPhase = 1;
      end
    end else if (mPhase == 1 && startSize == 0) begin
      mPhase = 2;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic idle();
    w_regwrite = 1'b0; m_memread = 1'b0; m_memwrite = 1'b0; hlt = 1'b0;
  endtask

  task automatic doReset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic ev_t expHead();
    ev_t e;
    e = '0;
    if (mq.size() > 0) e = mq[0];
    return e;
  endfunction

  task automatic randomInputs();
    w_regwrite = 1'($urandom_range(0, 1));
    w_dest     = 4'($urandom);
    w_data     = 16'($urandom);
    m_memread  = 1'($urandom_range(0, 1));
    m_memwrite = 1'($urandom_range(0, 1));
    m_addr     = 16'($urandom);
    m_wdata    = 16'($urandom);
    m_rdata    = 16'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; w_regwrite = 1'b1; m_memwrite = 1'b1; hlt = 1'b1; ev_ready = 1'b1;
    tick();
    nChecks++; if (ev_valid !== 1'b0) $display("FAIL reset_ev_valid: got %b want 0", ev_valid); else nPass++;
    nChecks++; if (cycle_cnt !== 32'd0) $display("FAIL reset_cycle_cnt: got %0d want 0", cycle_cnt); else nPass++;
    nChecks++; if (inst_cnt !== 32'd0) $display("FAIL reset_inst_cnt: got %0d want 0", inst_cnt); else nPass++;
    nChecks++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); else nPass++;
    nChecks++; if ({overflow, timeout, done} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {overflow, timeout, done}); else nPass++;
    idle();
    rst = 1'b0;
    tick();
    nChecks++; if (cycle_cnt !== 32'd1) $display("FAIL reset_run_state: cycle_cnt got %0d want 1", cycle_cnt); else nPass++;
  endtask

  task automatic test_reg_store();
    doReset();
    ev_ready = 1'b1;
    w_regwrite = 1'b1; w_dest = 4'd3; w_data = 16'h1234;
    m_memwrite = 1'b1; m_addr = 16'h0040; m_wdata = 16'hBEEF;
    tick();
    idle();
    nChecks++; if ({ev_valid, ev_type, ev_tag, ev_value} !== {1'b1, 2'b00, 16'h0003, 16'h1234})
      $display("FAIL reg_store_first: got %b/%b/%h/%h want 1/00/0003/1234", ev_valid, ev_type, ev_tag, ev_value); else nPass++;
    nChecks++; if (inst_cnt !== 32'd1) $display("FAIL reg_store_inst_cnt: got %0d want 1", inst_cnt); else nPass++;
    tick();
    nChecks++; if ({ev_valid, ev_type, ev_tag, ev_value} !== {1'b1, 2'b10, 16'h0040, 16'hBEEF})
      $display("FAIL reg_store_second: got %b/%b/%h/%h want 1/10/0040/beef", ev_valid, ev_type, ev_tag, ev_value); else nPass++;
    tick();
    nChecks++; if (ev_valid !== 1'b0) $display("FAIL reg_store_empty: got %b want 0", ev_valid); else nPass++;
  endtask

  task automatic test_load_mask();
    doReset();
    ev_ready = 1'b1;
    m_memread = 1'b1; m_memwrite = 1'b1; m_addr = 16'h0020; m_wdata = 16'h5555; m_rdata = 16'h9999;
    tick();
    idle();
    nChecks++; if ({ev_type, ev_tag, ev_value} !== {2'b10, 16'h0020, 16'h5555})
      $display("FAIL mask_store_only: got %b/%h/%h want 10/0020/5555", ev_type, ev_tag, ev_value); else nPass++;
    tick();
    nChecks++; if (ev_valid !== 1'b0) $display("FAIL mask_single_event: ev_valid got %b want 0", ev_valid); else nPass++;
    m_memread = 1'b1; m_addr = 16'h0010; m_rdata = 16'h00AA; m_wdata = 16'h7777;
    tick();
    idle();
    nChecks++; if ({ev_valid, ev_type, ev_tag, ev_value} !== {1'b1, 2'b01, 16'h0010, 16'h00AA})
      $display("FAIL load_event: got %b/%b/%h/%h want 1/01/0010/00aa", ev_valid, ev_type, ev_tag, ev_value); else nPass++;
    nChecks++; if (inst_cnt !== 32'd1) $display("FAIL load_inst_cnt: got %0d want 1", inst_cnt); else nPass++;
  endtask

  task automatic test_overflow();
    int pops;
    doReset();
    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w_regwrite = 1'b1; w_dest = 4'(i); w_data = 16'($urandom);
      m_memwrite = 1'b1; m_addr = 16'($urandom); m_wdata = 16'($urandom);
      tick();
    end
    idle();
    nChecks++; if (drop_cnt !== 16'd2) $display("FAIL ovf_drop_cnt: got %0d want 2", drop_cnt); else nPass++;
    nChecks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else nPass++;
    ev_ready = 1'b1;
    pops = 0;
    for (int k = 0; k < 20 && ev_valid; k++) begin
      nChecks++; if ({ev_type, ev_tag, ev_value} !== expHead())
        $display("FAIL ovf_order: pop %0d got %h want %h", pops, {ev_type, ev_tag, ev_value}, expHead()); else nPass++;
      tick();
      pops++;
    end
    nChecks++; if (pops !== 8) $display("FAIL ovf_pop_count: got %0d want 8", pops); else nPass++;
    nChecks++; if (ev_valid !== 1'b0) $display("FAIL ovf_valid_fall: got %b want 0", ev_valid); else nPass++;
  endtask

  task automatic test_full_pop();
    int pops;
    doReset();
    ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_regwrite = 1'b1; w_dest = 4'(i + 4); w_data = 16'($urandom);
      m_memwrite = 1'b1; m_addr = 16'($urandom); m_wdata = 16'($urandom);
      tick();
    end
    idle();
    nChecks++; if ({overflow, drop_cnt} !== 17'd0) $display("FAIL full_fill: got ovf=%b drop=%0d want 0/0", overflow, drop_cnt); else nPass++;
    ev_ready = 1'b1;
    w_regwrite = 1'b1; w_dest = 4'd9; w_data = 16'hC0DE;
    tick();
    idle();
    ev_ready = 1'b0;
    nChecks++; if (drop_cnt !== 16'd0) $display("FAIL full_pop_drop: got %0d want 0", drop_cnt); else nPass++;
    nChecks++; if (overflow !== 1'b0) $display("FAIL full_pop_ovf: got %b want 0", overflow); else nPass++;
    ev_ready = 1'b1;
    pops = 0;
    for (int k = 0; k < 20 && ev_valid; k++) begin
      nChecks++; if ({ev_type, ev_tag, ev_value} !== expHead())
        $display("FAIL full_pop_order: pop %0d got %h want %h", pops, {ev_type, ev_tag, ev_value}, expHead()); else nPass++;
      tick();
      pops++;
    end
    nChecks++; if (pops !== 8) $display("FAIL full_pop_occupancy: got %0d want 8", pops); else nPass++;
  endtask

  task automatic test_halt_drain();
    int pops;
    doReset();
    ev_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w_regwrite = 1'b1; w_dest = 4'(i + 1); w_data = 16'($urandom);
      tick();
    end
    idle();
    repeat (6) tick();
    hlt = 1'b1; m_memwrite = 1'b1; m_addr = 16'h0100; m_wdata = 16'hFACE;
    tick();
    idle();
    nChecks++; if (inst_cnt !== 32'd4) $display("FAIL halt_inst_cnt: got %0d want 4", inst_cnt); else nPass++;
    nChecks++; if (cycle_cnt !== 32'd10) $display("FAIL halt_cycle_cnt: got %0d want 10", cycle_cnt); else nPass++;
    for (int k = 0; k < 5; k++) begin
      randomInputs();
      hlt = 1'($urandom_range(0, 1));
      tick();
    end
    nChecks++; if ({cycle_cnt, inst_cnt} !== {32'd10, 32'd4}) $display("FAIL halt_frozen: got %0d/%0d want 10/4", cycle_cnt, inst_cnt); else nPass++;
    nChecks++; if ({done, timeout} !== 2'b00) $display("FAIL halt_not_done: got done=%b tmo=%b want 0/0", done, timeout); else nPass++;
    ev_ready = 1'b1;
    pops = 0;
    for (int k = 0; k < 12 && ev_valid; k++) begin
      nChecks++; if ({ev_type, ev_tag, ev_value} !== expHead())
        $display("FAIL halt_order: pop %0d got %h want %h", pops, {ev_type, ev_tag, ev_value}, expHead()); else nPass++;
      randomInputs();
      tick();
      pops++;
    end
    nChecks++; if (pops !== 4) $display("FAIL halt_pop_count: got %0d want 4", pops); else nPass++;
    nChecks++; if (done !== 1'b0) $display("FAIL halt_done_early: got %b want 0", done); else nPass++;
    randomInputs();
    tick();
    idle();
    nChecks++; if (done !== 1'b1) $display("FAIL halt_done: got %b want 1", done); else nPass++;
    tick();
    nChecks++; if ({ev_valid, cycle_cnt} !== {1'b0, 32'd10}) $display("FAIL halt_after_done: got valid=%b cyc=%0d want 0/10", ev_valid, cycle_cnt); else nPass++;
  endtask

  task automatic test_halt_at_limit();
    doReset();
    ev_ready = 1'b1;
    repeat (MAXC - 1) tick();
    hlt = 1'b1;
    tick();
    idle();
    nChecks++; if (cycle_cnt !== 32'(MAXC)) $display("FAIL limit_halt_cycle: got %0d want %0d", cycle_cnt, MAXC); else nPass++;
    nChecks++; if (timeout !== 1'b0) $display("FAIL limit_halt_timeout: got %b want 0", timeout); else nPass++;
    tick();
    nChecks++; if (done !== 1'b1) $display("FAIL limit_halt_done: got %b want 1", done); else nPass++;
  endtask

  task automatic test_timeout();
    doReset();
    ev_ready = 1'b0;
    for (int c = 1; c <= MAXC; c++) begin
      w_regwrite = (c == 2 || c == 18);
      w_dest = 4'(c); w_data = 16'($urandom);
      tick();
      idle();
      if (c == MAXC - 1) begin
        nChecks++; if ({timeout, cycle_cnt} !== {1'b0, 32'(MAXC - 1)}) $display("FAIL tmo_before_limit: got tmo=%b cyc=%0d want 0/%0d", timeout, cycle_cnt, MAXC - 1); else nPass++;
      end
    end
    nChecks++; if (cycle_cnt !== 32'(MAXC)) $display("FAIL tmo_cycle_cnt: got %0d want %0d", cycle_cnt, MAXC); else nPass++;
    nChecks++; if (timeout !== 1'b1) $display("FAIL tmo_flag: got %b want 1", timeout); else nPass++;
    ev_ready = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      randomInputs();
      tick();
    end
    idle();
    nChecks++; if ({done, ev_valid, timeout} !== 3'b101) $display("FAIL tmo_done: got done/valid/tmo=%b want 101", {done, ev_valid, timeout}); else nPass++;
    nChecks++; if (cycle_cnt !== 32'(MAXC)) $display("FAIL tmo_frozen: got %0d want %0d", cycle_cnt, MAXC); else nPass++;

    // Reset pulsed while draining a full queue
    doReset();
    ev_ready = 1'b0;
    for (int c = 1; c <= MAXC; c++) begin
      w_regwrite = 1'b1; w_dest = 4'(c); w_data = 16'($urandom);
      tick();
    end
    idle();
    nChecks++; if ({ev_valid, done, timeout, overflow} !== 4'b1011) $display("FAIL tmo_in_drain: got %b want 1011", {ev_valid, done, timeout, overflow}); else nPass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nChecks++; if ({ev_valid, overflow, timeout, done} !== 4'b0000) $display("FAIL drain_reset_flags: got %b want 0000", {ev_valid, overflow, timeout, done}); else nPass++;
    nChecks++; if ({cycle_cnt, inst_cnt, drop_cnt} !== 80'd0) $display("FAIL drain_reset_counts: got %0d/%0d/%0d want 0/0/0", cycle_cnt, inst_cnt, drop_cnt); else nPass++;
    ev_ready = 1'b1;
    w_regwrite = 1'b1; w_dest = 4'd5; w_data = 16'h0505;
    tick();
    idle();
    nChecks++; if ({ev_valid, ev_tag, cycle_cnt} !== {1'b1, 16'h0005, 32'd1}) $display("FAIL drain_reset_run: got valid=%b tag=%h cyc=%0d want 1/0005/1", ev_valid, ev_tag, cycle_cnt); else nPass++;
  endtask

  task automatic test_random();
    for (int ep = 0; ep < 8; ep++) begin
      doReset();
      for (int c = 0; c < 40; c++) begin
        randomInputs();
        hlt = ($urandom_range(0, 15) == 0);
        ev_ready = 1'($urandom_range(0, 1));
        tick();
        nChecks++; if ({ev_valid, ev_type, ev_tag, ev_value} !== {(mq.size() != 0), expHead()})
          $display("FAIL rand_head: ep %0d cyc %0d got %b/%h want %b/%h", ep, c, ev_valid, {ev_type, ev_tag, ev_value}, (mq.size() != 0), expHead()); else nPass++;
        nChecks++; if ({cycle_cnt, inst_cnt, drop_cnt} !== {32'(mCycle), 32'(mInst), 16'(mDrop)})
          $display("FAIL rand_counters: ep %0d cyc %0d got %0d/%0d/%0d want %0d/%0d/%0d", ep, c, cycle_cnt, inst_cnt, drop_cnt, mCycle, mInst, mDrop); else nPass++;
        nChecks++; if ({overflow, timeout, done} !== {mOvf, mTmo, (mPhase == 2)})
          $display("FAIL rand_flags: ep %0d cyc %0d got %b want %b", ep, c, {overflow, timeout, done}, {mOvf, mTmo, (mPhase == 2)}); else nPass++;
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_reg_store();
    test_load_mask();
    test_overflow();
    test_full_pop();
    test_halt_drain();
    test_halt_at_limit();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
